// File: rtl/layer_sequencer.sv
// Chains NUM_LAYERS layer controllers through one-hot start/done handshakes for a batch of images.
// Latency: start -> layer_start[0] two edges; layer_done -> next layer_start two edges; last done -> done two edges.
// Backpressure: none; each layer holds the sequencer in WAIT until its done pulse, and abort wins over everything.
//
// Optional build macro LAYER_WATCHDOG_EN adds a per-layer WAIT watchdog (WDOG_CYCLES) driving timeout.
// Ports: clk/rst_n (async active-low); start, abort, img_count, layer_done in;
//        layer_start, mac_sel, cur_layer, img_idx, busy, done, err, timeout out (all registered).
module layer_sequencer #(
    parameter int unsigned                  NUM_LAYERS  = 8,
    parameter int unsigned                  CNT_W       = 8,
    parameter int unsigned                  SEL_W       = 1,
    parameter logic [NUM_LAYERS*SEL_W-1:0]  SEL_MAP     = 8'b0000_1111,
    parameter int unsigned                  WDOG_CYCLES = 65536
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            start,
    input  logic                            abort,
    input  logic [CNT_W-1:0]                img_count,
    input  logic [NUM_LAYERS-1:0]           layer_done,
    output logic [NUM_LAYERS-1:0]           layer_start,
    output logic [SEL_W-1:0]                mac_sel,
    output logic [$clog2(NUM_LAYERS)-1:0]   cur_layer,
    output logic [CNT_W-1:0]                img_idx,
    output logic                            busy,
    output logic                            done,
    output logic                            err,
    output logic                            timeout
);
    localparam int unsigned LW = $clog2(NUM_LAYERS);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LAUNCH = 2'd1,
        S_WAIT   = 2'd2,
        S_FINISH = 2'd3
    } state_e;

    state_e                 state_q, state_d;
    logic [LW-1:0]          cur_q, cur_d;
    logic [CNT_W-1:0]       img_q, img_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [NUM_LAYERS-1:0]  start_q, start_d;
    logic [SEL_W-1:0]       mac_q, mac_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic                   err_q, err_d;

    logic [NUM_LAYERS-1:0]  cur_oh;
    logic                   valid_done;
    logic                   spurious;

`ifdef LAYER_WATCHDOG_EN
    localparam int unsigned WW = (WDOG_CYCLES > 1) ? $clog2(WDOG_CYCLES) : 1;
    logic [WW-1:0]          wdog_q, wdog_d;
    logic                   timeout_q, timeout_d;
`endif

    assign cur_oh     = NUM_LAYERS'(1) << cur_q;
    assign valid_done = (state_q == S_WAIT) && layer_done[cur_q];
    // Any done bit that is not the active layer's done while waiting is a protocol error.
    assign spurious   = (state_q == S_WAIT) ? |(layer_done & ~cur_oh) : |layer_done;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        cur_d   = cur_q;
        img_d   = img_q;
        cnt_d   = cnt_q;
        start_d = '0;
        mac_d   = mac_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        err_d   = err_q;
`ifdef LAYER_WATCHDOG_EN
        wdog_d    = wdog_q;
        timeout_d = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                if (start && !abort) begin
                    cnt_d   = (img_count == '0) ? CNT_W'(1) : img_count;
                    err_d   = 1'b0;
                    img_d   = '0;
                    cur_d   = '0;
                    busy_d  = 1'b1;
                    state_d = S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                start_d = cur_oh;
                mac_d   = SEL_MAP[cur_q*SEL_W +: SEL_W];
`ifdef LAYER_WATCHDOG_EN
                wdog_d  = '0;
`endif
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (valid_done) begin
                    if (cur_q != LW'(NUM_LAYERS - 1)) begin
                        cur_d   = cur_q + LW'(1);
                        state_d = S_LAUNCH;
                    end else if (img_q != cnt_q - CNT_W'(1)) begin
                        img_d   = img_q + CNT_W'(1);
                        cur_d   = '0;
                        state_d = S_LAUNCH;
                    end else begin
                        state_d = S_FINISH;
                    end
                end
            end
            default: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                mac_d   = '0;
                state_d = S_IDLE;
            end
        endcase

`ifdef LAYER_WATCHDOG_EN
        // Watchdog expiry behaves like an abort but flags the stall.
        if (state_q == S_WAIT && !valid_done && !abort) begin
            if (wdog_q == WW'(WDOG_CYCLES - 1)) begin
                state_d   = S_IDLE;
                busy_d    = 1'b0;
                mac_d     = '0;
                err_d     = 1'b1;
                timeout_d = 1'b1;
            end else begin
                wdog_d = wdog_q + WW'(1);
            end
        end
`endif

        // Abort outranks any done or start seen in the same cycle; layer/image indices are frozen.
        if (abort && state_q != S_IDLE) begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
            mac_d   = '0;
            done_d  = 1'b0;
            start_d = '0;
            cur_d   = cur_q;
            img_d   = img_q;
        end

        if (spurious) err_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_q   <= '0;
            img_q   <= '0;
            cnt_q   <= '0;
            start_q <= '0;
            mac_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            cur_q   <= cur_d;
            img_q   <= img_d;
            cnt_q   <= cnt_d;
            start_q <= start_d;
            mac_q   <= mac_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

`ifdef LAYER_WATCHDOG_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wdog_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            wdog_q    <= wdog_d;
            timeout_q <= timeout_d;
        end
    end
    assign timeout = timeout_q;
`else
    assign timeout = 1'b0;
`endif

    assign layer_start = start_q;
    assign mac_sel     = mac_q;
    assign cur_layer   = cur_q;
    assign img_idx     = img_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign err         = err_q;
endmodule
